call_display_ctrl: RTL and testbench

// - Downstream of the queue-number response system: consumes counter-call events
//   (counter A..E + service number) and shows each on a 4-digit multiplexed 7-seg display.
// - Buffers pending calls in a small FIFO and shows each for a fixed hold time.
// - Digits left to right: counter letter, dash, tens, ones.

---
 rtl/call_display_ctrl.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_call_display_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/call_display_ctrl.sv
// call_display_ctrl: buffers counter-call events in a small FIFO and shows each
// one on a 4-digit multiplexed 7-segment display (letter, dash, tens, ones).
// Optional feature macro: CALL_BLINK_EN. When it is defined, the shown call
// blinks on and off every BLINK_DIV cycles. The hold time stays the same.
// All display outputs are registered from next-state values. As a result, an
// and seg line up with the FSM state of the same cycle.
module call_display_ctrl #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 50,
    parameter int SCAN_DIV    = 4
`ifdef CALL_BLINK_EN
    ,
    parameter int BLINK_DIV   = 8
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       call_valid,
    input  logic [2:0] call_counter,
    input  logic [5:0] call_number,
    output logic       call_ready,
    output logic       busy,
    output logic       drop,
    output logic [3:0] an,
    output logic [6:0] seg
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 2);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] SCAN_ONE = SW'(1);
    localparam logic [SW-1:0] SCAN_END = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHOW, ST_GAP} state_t;

    // Standard active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  4'hF: hex7 = 7'h0E;
            default: hex7 = 7'h7F;
        endcase
    endfunction

    logic [2:0]    r_mem_id  [DEPTH];
    logic [5:0]    r_mem_num [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count, w_count_n;
    state_t        r_state, w_state_n;
    logic [HW-1:0] r_hold, w_hold_n;
    logic [SW-1:0] r_scan_cnt, w_scan_cnt_n;
    logic [1:0]    r_idx, w_idx_n;
    logic [2:0]    r_id;
    logic [5:0]    r_num;
    logic [3:0]    r_tens, r_ones, w_div_tens, w_div_ones, w_tens_n, w_ones_n;
    logic [3:0]    r_an, w_an_n;
    logic [6:0]    r_seg, w_seg_n;
    logic          r_ready, r_busy, r_drop;
    logic          w_full, w_empty, w_id_ok, w_push, w_pop, w_drop_n, w_blink_on;

    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == {CW{1'b0}});
    assign w_id_ok  = (call_counter <= 3'd4);
    assign w_push   = call_valid & ~w_full & w_id_ok;
    assign w_pop    = (r_state == ST_IDLE) & ~w_empty;
    assign w_drop_n = call_valid & (w_full | ~w_id_ok);

    // FIFO occupancy: simultaneous push and pop leave the count unchanged
    always_comb begin
        w_count_n = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_n = r_count + CNT_ONE;
            2'b01:   w_count_n = r_count - CNT_ONE;
            default: w_count_n = r_count;
        endcase
    end

    // FSM next state and the shared hold/gap cycle counter
    always_comb begin
        w_state_n = r_state;
        w_hold_n  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_pop) begin
                    w_state_n = ST_LOAD;
                end else begin
                    w_state_n = ST_IDLE;
                end
                w_hold_n = {HW{1'b0}};
            end
            ST_LOAD: begin
                w_state_n = ST_SHOW;
                w_hold_n  = {HW{1'b0}};
            end
            ST_SHOW: begin
                if (r_hold == HOLD_END) begin
                    w_state_n = ST_GAP;
                    w_hold_n  = {HW{1'b0}};
                end else begin
                    w_hold_n  = r_hold + HOLD_ONE;
                end
            end
            ST_GAP: begin
                if (r_hold == HOLD_ONE) begin
                    w_state_n = ST_IDLE;
                    w_hold_n  = {HW{1'b0}};
                end else begin
                    w_hold_n  = r_hold + HOLD_ONE;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_hold_n  = {HW{1'b0}};
            end
        endcase
    end

    // Free-running digit scan: the index advances once every SCAN_DIV cycles
    always_comb begin
        w_scan_cnt_n = r_scan_cnt;
        w_idx_n      = r_idx;
        if (r_scan_cnt == SCAN_END) begin
            w_scan_cnt_n = {SW{1'b0}};
            w_idx_n      = r_idx + 2'd1;
        end else begin
            w_scan_cnt_n = r_scan_cnt + SCAN_ONE;
        end
    end

    // Decimal split of the 0..63 service number by a compare ladder
    always_comb begin
        w_div_tens = 4'd0;
        if (r_num >= 6'd60)      begin w_div_tens = 4'd6; end
        else if (r_num >= 6'd50) begin w_div_tens = 4'd5; end
        else if (r_num >= 6'd40) begin w_div_tens = 4'd4; end
        else if (r_num >= 6'd30) begin w_div_tens = 4'd3; end
        else if (r_num >= 6'd20) begin w_div_tens = 4'd2; end
        else if (r_num >= 6'd10) begin w_div_tens = 4'd1; end
        else                     begin w_div_tens = 4'd0; end
        w_div_ones = 4'(r_num - (6'(w_div_tens) * 6'd10));
    end

    assign w_tens_n = (r_state == ST_LOAD) ? w_div_tens : r_tens;
    assign w_ones_n = (r_state == ST_LOAD) ? w_div_ones : r_ones;

`ifdef CALL_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_ONE = BW'(1);
    localparam logic [BW-1:0] BLINK_END = BW'(BLINK_DIV - 1);
    logic [BW-1:0] r_blink_cnt, w_blink_cnt_n;
    logic          r_phase, w_phase_n;

    // Blink phase: restarts in the on phase at SHOW entry and toggles every BLINK_DIV cycles
    always_comb begin
        w_blink_cnt_n = r_blink_cnt;
        w_phase_n     = r_phase;
        if ((w_state_n == ST_SHOW) && (r_state != ST_SHOW)) begin
            w_blink_cnt_n = {BW{1'b0}};
            w_phase_n     = 1'b0;
        end else if (r_state == ST_SHOW) begin
            if (r_blink_cnt == BLINK_END) begin
                w_blink_cnt_n = {BW{1'b0}};
                w_phase_n     = ~r_phase;
            end else begin
                w_blink_cnt_n = r_blink_cnt + BLINK_ONE;
            end
        end else begin
            w_blink_cnt_n = {BW{1'b0}};
            w_phase_n     = 1'b0;
        end
    end

    // Blink phase registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blink_cnt <= {BW{1'b0}};
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_n;
            r_phase     <= w_phase_n;
        end
    end

    assign w_blink_on = ~w_phase_n;
`else
    assign w_blink_on = 1'b1;
`endif

    // Next display pattern: a single active digit only while showing, otherwise blank
    always_comb begin
        w_an_n  = 4'hF;
        w_seg_n = 7'h7F;
        if ((w_state_n == ST_SHOW) && w_blink_on) begin
            case (w_idx_n)
                2'd3: begin w_an_n = 4'b0111; w_seg_n = hex7(4'd10 + {1'b0, r_id}); end
                2'd2: begin w_an_n = 4'b1011; w_seg_n = 7'b0111111; end
                2'd1: begin
                    w_an_n  = 4'b1101;
                    w_seg_n = (w_tens_n == 4'd0) ? 7'h7F : hex7(w_tens_n);
                end
                2'd0: begin w_an_n = 4'b1110; w_seg_n = hex7(w_ones_n); end
                default: begin w_an_n = 4'hF; w_seg_n = 7'h7F; end
            endcase
        end else begin
            w_an_n  = 4'hF;
            w_seg_n = 7'h7F;
        end
    end

    // FIFO storage and pointers; a reset drops all pending calls
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_id[i]  <= 3'd0;
                r_mem_num[i] <= 6'd0;
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem_id[r_wr_ptr]  <= call_counter;
                r_mem_num[r_wr_ptr] <= call_number;
                r_wr_ptr            <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_n;
        end
    end

    // FSM state, hold counter, popped call and its decimal digits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_hold  <= {HW{1'b0}};
            r_id    <= 3'd0;
            r_num   <= 6'd0;
            r_tens  <= 4'd0;
            r_ones  <= 4'd0;
        end else begin
            r_state <= w_state_n;
            r_hold  <= w_hold_n;
            if (w_pop) begin
                r_id  <= r_mem_id[r_rd_ptr];
                r_num <= r_mem_num[r_rd_ptr];
            end
            r_tens <= w_tens_n;
            r_ones <= w_ones_n;
        end
    end

    // Scan counter and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan_cnt <= {SW{1'b0}};
            r_idx      <= 2'd0;
            r_an       <= 4'hF;
            r_seg      <= 7'h7F;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_scan_cnt <= w_scan_cnt_n;
            r_idx      <= w_idx_n;
            r_an       <= w_an_n;
            r_seg      <= w_seg_n;
            r_ready    <= (w_count_n != CNT_FULL);
            r_busy     <= (w_state_n != ST_IDLE) | (w_count_n != {CW{1'b0}});
            r_drop     <= w_drop_n;
        end
    end

    assign an         = r_an;
    assign seg        = r_seg;
    assign call_ready = r_ready;
    assign busy       = r_busy;
    assign drop       = r_drop;
endmodule

// File: tb/tb_call_display_ctrl.sv
// Testbench for call_display_ctrl: table-driven single-call vectors plus
// hand-written sequences for reset, FIFO full/drop, ordering and invalid ids.
module tb_call_display_ctrl;
    localparam int HOLD  = 50;
    localparam int BLINK = 8;
    localparam int PERIOD_CALL = HOLD + 4; // SHOW + GAP(2) + IDLE(1) + LOAD(1)

    logic       clk = 1'b0;
    logic       rst, call_valid;
    logic [2:0] call_counter;
    logic [5:0] call_number;
    logic       call_ready, busy, drop;
    logic [3:0] an;
    logic [6:0] seg;

    call_display_ctrl dut (
        .clk(clk), .rst(rst), .call_valid(call_valid), .call_counter(call_counter),
        .call_number(call_number), .call_ready(call_ready), .busy(busy), .drop(drop),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] id;
        logic [5:0] num;
        logic [6:0] d3, d2, d1, d0;
    } vec_t;

    vec_t       vecs [6];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [6:0] cap [4];
    logic [3:0] cap_seen;
    int         bad_an;
    int         exp_on;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Record the segment pattern of whichever digit is currently enabled
    task automatic sample_digit;
        case (an)
            4'b1110: begin cap[0] = seg; cap_seen[0] = 1'b1; end
            4'b1101: begin cap[1] = seg; cap_seen[1] = 1'b1; end
            4'b1011: begin cap[2] = seg; cap_seen[2] = 1'b1; end
            4'b0111: begin cap[3] = seg; cap_seen[3] = 1'b1; end
            4'b1111: begin end
            default: bad_an++;
        endcase
    endtask

    task automatic check_digits(input string tag, input vec_t v);
        if (cap_seen[3]) check({tag, "_d3"}, cap[3], v.d3);
        if (cap_seen[2]) check({tag, "_d2"}, cap[2], v.d2);
        if (cap_seen[1]) check({tag, "_d1"}, cap[1], v.d1);
        if (cap_seen[0]) check({tag, "_d0"}, cap[0], v.d0);
`ifndef CALL_BLINK_EN
        check({tag, "_seen"}, cap_seen, 4'hF);
`else
        check({tag, "_seen_any"}, (cap_seen != 4'h0), 1'b1);
`endif
        check({tag, "_an_shape"}, bad_an, 0);
    endtask

    task automatic push(input logic [2:0] id, input logic [5:0] num);
        call_valid   = 1'b1;
        call_counter = id;
        call_number  = num;
        tick();
        call_valid   = 1'b0;
    endtask

    // One complete call from accept to return to idle
    task automatic run_vec(input vec_t v);
        int n_on, n_ticks;
        push(v.id, v.num);                       // edge E0
        check("accept_busy", busy, 1'b1);
        check("accept_ready", call_ready, 1'b1);
        tick();                                  // E1: LOAD
        check("load_blank", an, 4'hF);
        tick();                                  // E2: SHOW
        check("show_start", (an != 4'hF), 1'b1);
        cap_seen = 4'h0; bad_an = 0; n_on = 0; n_ticks = 0;
        while (busy === 1'b1 && n_ticks < 300) begin
            sample_digit();
            if (an != 4'hF) n_on++;
            tick();
            n_ticks++;
        end
        check_digits("vec", v);
        check("hold_len", n_on, exp_on);
        check("idle_after", n_ticks, HOLD + 2);
        check("idle_blank", an, 4'hF);
    endtask

    task automatic advance_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'd2, 6'd37, 7'h46, 7'h3F, 7'h30, 7'h78};
        vecs[1] = '{3'd0, 6'd5,  7'h08, 7'h3F, 7'h7F, 7'h12};
        vecs[2] = '{3'd4, 6'd63, 7'h06, 7'h3F, 7'h02, 7'h30};
        vecs[3] = '{3'd1, 6'd10, 7'h03, 7'h3F, 7'h79, 7'h40};
        vecs[4] = '{3'd3, 6'd0,  7'h21, 7'h3F, 7'h7F, 7'h40};
        vecs[5] = '{3'd1, 6'd49, 7'h03, 7'h3F, 7'h19, 7'h10};

        exp_on = 0;
        for (int c = 0; c < HOLD; c++) begin
`ifdef CALL_BLINK_EN
            if (((c / BLINK) % 2) == 0) exp_on++;
`else
            exp_on++;
`endif
        end

        // Reset state
        rst = 1'b1; call_valid = 1'b0; call_counter = 3'd0; call_number = 6'd0;
        #2 rst = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_ready", call_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_drop", drop, 1'b0);
        tick(); tick();
        rst = 1'b1;
        tick();

        // Table-driven single calls
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // FIFO fill during SHOW, overflow drop, strict ordering
        begin
            int t0;
            vec_t exp_ord [4];
            exp_ord[0] = '{3'd1, 6'd11, 7'h03, 7'h3F, 7'h79, 7'h79};
            exp_ord[1] = '{3'd2, 6'd22, 7'h46, 7'h3F, 7'h24, 7'h24};
            exp_ord[2] = '{3'd3, 6'd33, 7'h21, 7'h3F, 7'h30, 7'h30};
            exp_ord[3] = '{3'd4, 6'd44, 7'h06, 7'h3F, 7'h19, 7'h19};
            push(3'd0, 6'd1);
            tick();
            tick();
            t0 = cyc;                            // first call enters SHOW
            for (int j = 0; j < 4; j++) begin
                push(exp_ord[j].id, exp_ord[j].num);
                check("fill_nodrop", drop, 1'b0);
            end
            check("full_ready", call_ready, 1'b0);
            push(3'd0, 6'd55);
            check("full_drop", drop, 1'b1);
            check("full_busy", busy, 1'b1);
            tick();
            check("full_drop_pulse", drop, 1'b0);
            check("full_still", call_ready, 1'b0);
            for (int j = 0; j < 4; j++) begin
                advance_to(t0 + (j + 1) * PERIOD_CALL - 1);
                check("order_load_blank", an, 4'hF);
                tick();
                check("order_show_start", (an != 4'hF), 1'b1);
                cap_seen = 4'h0; bad_an = 0;
                for (int k = 0; k < 16; k++) begin
                    sample_digit();
                    tick();
                end
                check_digits("order", exp_ord[j]);
            end
            check("order_ready_back", call_ready, 1'b1);
            begin
                int w;
                w = 0;
                while (busy === 1'b1 && w < 300) begin tick(); w++; end
                check("order_idle", busy, 1'b0);
            end
        end

        // Invalid counter id: dropped, never shown
        push(3'd6, 6'd10);
        check("inv_drop", drop, 1'b1);
        check("inv_busy", busy, 1'b0);
        check("inv_an", an, 4'hF);
        tick();
        check("inv_drop_pulse", drop, 1'b0);
        tick(); tick();
        check("inv_still_blank", an, 4'hF);
        check("inv_still_idle", busy, 1'b0);

        // Reset in the middle of a SHOW with calls pending
        push(3'd2, 6'd37);
        tick(); tick(); tick();
        push(3'd3, 6'd12);
        push(3'd4, 6'd20);
        check("pre_rst_show", (an != 4'hF), 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_ready", call_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("postrst_busy", busy, 1'b0);
        check("postrst_an", an, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
